// File: rtl/ddr2_v11_0_if_csr_m0_bytes_to_packets.sv
// Decodes the host byte link (SOP/EOP/channel/escape control codes) into packet beats
// held in a single registered output stage with a ready/valid handshake.
module ddr2_v11_0_if_csr_m0_bytes_to_packets #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
);

    localparam logic [7:0] SOP_CODE  = 8'h7A;
    localparam logic [7:0] EOP_CODE  = 8'h7B;
    localparam logic [7:0] CHAN_CODE = 8'h7C;
    localparam logic [7:0] ESC_CODE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    logic                     escape_pending_q, escape_pending_d;
    logic                     channel_pending_q, channel_pending_d;
    logic                     pending_sop_q, pending_sop_d;
    logic                     pending_eop_q, pending_eop_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;

    logic                     out_valid_q, out_valid_d;
    logic [7:0]               out_data_q, out_data_d;
    logic [CHANNEL_WIDTH-1:0] out_channel_q, out_channel_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;

    logic                     accept;
    logic                     data_beat;
    logic [7:0]               byte_val;

    assign in_ready          = out_ready || !out_valid_q;
    assign accept            = in_valid && in_ready;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_channel       = out_channel_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;

    always_comb begin
        escape_pending_d  = escape_pending_q;
        channel_pending_d = channel_pending_q;
        pending_sop_d     = pending_sop_q;
        pending_eop_d     = pending_eop_q;
        channel_d         = channel_q;
        out_valid_d       = out_valid_q;
        out_data_d        = out_data_q;
        out_channel_d     = out_channel_q;
        out_sop_d         = out_sop_q;
        out_eop_d         = out_eop_q;
        data_beat         = 1'b0;
        byte_val          = in_data;

        if (accept) begin
            if (escape_pending_q) begin
                // Escaped bytes bypass control decoding; only channel_pending routes them.
                escape_pending_d = 1'b0;
                byte_val         = in_data ^ ESC_XOR;
                if (channel_pending_q) begin
                    channel_d         = byte_val;
                    channel_pending_d = 1'b0;
                end else begin
                    data_beat = 1'b1;
                end
            end else begin
                unique case (in_data)
                    SOP_CODE: begin
                        pending_sop_d     = 1'b1;
                        pending_eop_d     = 1'b0;
                        channel_pending_d = 1'b0;
                        escape_pending_d  = 1'b0;
                    end
                    EOP_CODE:  pending_eop_d     = 1'b1;
                    CHAN_CODE: channel_pending_d = 1'b1;
                    ESC_CODE:  escape_pending_d  = 1'b1;
                    default: begin
                        if (channel_pending_q) begin
                            channel_d         = in_data;
                            channel_pending_d = 1'b0;
                        end else begin
                            data_beat = 1'b1;
                        end
                    end
                endcase
            end
        end

        if (data_beat) begin
            out_valid_d   = 1'b1;
            out_data_d    = byte_val;
            out_channel_d = channel_q;
            out_sop_d     = pending_sop_q;
            out_eop_d     = pending_eop_q;
            pending_sop_d = 1'b0;
            pending_eop_d = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            escape_pending_q  <= 1'b0;
            channel_pending_q <= 1'b0;
            pending_sop_q     <= 1'b0;
            pending_eop_q     <= 1'b0;
            channel_q         <= '0;
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_channel_q     <= '0;
            out_sop_q         <= 1'b0;
            out_eop_q         <= 1'b0;
        end else begin
            escape_pending_q  <= escape_pending_d;
            channel_pending_q <= channel_pending_d;
            pending_sop_q     <= pending_sop_d;
            pending_eop_q     <= pending_eop_d;
            channel_q         <= channel_d;
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
            out_channel_q     <= out_channel_d;
            out_sop_q         <= out_sop_d;
            out_eop_q         <= out_eop_d;
        end
    end

endmodule

// File: tb/tb_ddr2_v11_0_if_csr_m0_bytes_to_packets.sv
// Directed bench for the byte-to-packet decoder: expected beats are queued as bytes
// are driven and compared when the output handshake completes.
module tb_ddr2_v11_0_if_csr_m0_bytes_to_packets;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] out_channel;
    logic       out_startofpacket;
    logic       out_endofpacket;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] ch;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t exp_q[$];
    beat_t got;
    int    tests = 0;
    int    fails = 0;
    bit    toggle_mode = 1'b0;

    ddr2_v11_0_if_csr_m0_bytes_to_packets #(.CHANNEL_WIDTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] ch, input logic sop, input logic eop);
        exp_q.push_back('{d: d, ch: ch, sop: sop, eop: eop});
    endtask

    // Starts at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send(input logic [7:0] b, input bit beat);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (beat) chk("latency_valid", out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (toggle_mode) out_ready = ~out_ready;
    end

    // Handshake monitor: in_ready rule every cycle, beat contents on each transfer.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("in_ready_rule", in_ready, out_ready || !out_valid);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    chk("beat_data", out_data, got.d);
                    chk("beat_channel", out_channel, got.ch);
                    chk("beat_sop", out_startofpacket, got.sop);
                    chk("beat_eop", out_endofpacket, got.eop);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sop", out_startofpacket, 0);
        chk("rst_eop", out_endofpacket, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_channel", out_channel, 8'h00);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;

        // Basic packet with explicit channel 0
        push(8'h11, 8'h00, 1'b1, 1'b0);
        push(8'h22, 8'h00, 1'b0, 1'b0);
        push(8'h33, 8'h00, 1'b0, 1'b1);
        send(8'h7A, 0); send(8'h7C, 0); send(8'h00, 0);
        send(8'h11, 1); send(8'h22, 1); send(8'h7B, 0); send(8'h33, 1);
        drain();
        chk("idle_after_pkt1", out_valid, 0);

        // Escaped control codes as payload
        push(8'h7A, 8'h00, 1'b1, 1'b0);
        push(8'h7D, 8'h00, 1'b0, 1'b1);
        send(8'h7A, 0); send(8'h7D, 0); send(8'h5A, 1);
        send(8'h7B, 0); send(8'h7D, 0); send(8'h5D, 1);
        drain();

        // Escaped channel value, single-beat packet
        push(8'h44, 8'h7C, 1'b1, 1'b1);
        send(8'h7C, 0); send(8'h7D, 0); send(8'h5C, 0);
        send(8'h7A, 0); send(8'h7B, 0); send(8'h44, 1);
        drain();

        // Backpressure: beat held stable, then replaced on release
        push(8'h11, 8'h7C, 1'b1, 1'b0);
        push(8'h22, 8'h7C, 1'b0, 1'b0);
        out_ready = 1'b0;
        send(8'h7A, 0);
        send(8'h11, 1);
        in_valid = 1'b1;
        in_data  = 8'h22;
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 8'h11);
            chk("hold_sop", out_startofpacket, 1);
            chk("hold_channel", out_channel, 8'h7C);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release_valid", out_valid, 1);
        chk("release_data", out_data, 8'h22);
        drain();

        // Reset discards a held beat
        out_ready = 1'b0;
        send(8'h66, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_held_valid", out_valid, 0);
        chk("rst_held_data", out_data, 8'h00);
        reset     = 1'b0;
        out_ready = 1'b1;

        // Reset mid-decode clears channel, sop and escape
        send(8'h7C, 0); send(8'h09, 0); send(8'h7A, 0); send(8'h7D, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_channel", out_channel, 8'h00);
        reset = 1'b0;
        push(8'h55, 8'h00, 1'b0, 1'b0);
        send(8'h55, 1);
        drain();

        // Toggling out_ready
        toggle_mode = 1'b1;
        push(8'h55, 8'h03, 1'b0, 1'b0);
        send(8'h7C, 0); send(8'h03, 0); send(8'h55, 1);
        drain();
        toggle_mode = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", out_valid, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddr2_v11_0_if_csr_m0_bytes_to_packets.md
DDR2_V11_0_IF_CSR_M0_BYTES_TO_PACKETS -- requirements
Module: ddr2_v11_0_if_csr_m0_bytes_to_packets

Interface
REQ-001: Parameter CHANNEL_WIDTH, default 8, width of out_channel; the block SHALL support only the value 8.
REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: in_ready  output  1  block accepts in_data this cycle.
REQ-005: in_valid  input  1  in_data valid.
REQ-006: in_data  input  8  encoded byte stream from the host byte link.
REQ-007: out_ready  input  1  downstream channel adapter accepts output.
REQ-008: out_valid  output  1  output beat valid.
REQ-009: out_data  output  8  decoded payload byte.
REQ-010: out_channel  output  8  channel of the current packet.
REQ-011: out_startofpacket  output  1  beat is the first of a packet.
REQ-012: out_endofpacket  output  1  beat is the last of a packet.

Function
REQ-013: An input byte SHALL be consumed only on a cycle with in_valid && in_ready.
REQ-014: in_ready SHALL equal out_ready || !out_valid, giving one registered output stage with no bubble at full throughput.
REQ-015: Decoding SHALL use these control codes: 0x7A = SOP marker, 0x7B = EOP marker, 0x7C = channel marker, 0x7D = escape.
REQ-016: An unescaped 0x7A SHALL set pending_sop, produce no output beat, and clear any pending_eop.
REQ-017: An unescaped 0x7B SHALL set pending_eop and produce no output beat.
REQ-018: An unescaped 0x7C SHALL cause the next decoded byte, after any escape handling, to load the channel register instead of producing a beat.
REQ-019: An unescaped 0x7D SHALL cause the next consumed byte to be XORed with 0x20 and treated as ordinary data or channel, never as a control code.
REQ-020: Decode state SHALL be expressed as flags escape_pending, channel_pending, pending_sop, and pending_eop.
REQ-021: escape_pending and channel_pending may be set together (0x7C 0x7D x loads channel x^0x20).
REQ-022: Any other consumed byte, or any escaped byte when channel_pending = 0, SHALL be a data byte.
REQ-023: A data byte SHALL load the output register with out_data = byte, out_channel = channel register, out_startofpacket = pending_sop, out_endofpacket = pending_eop, and out_valid = 1.
REQ-024: Consuming a data byte SHALL clear pending_sop and pending_eop in the same cycle.
REQ-025: Latency SHALL be exactly one clk from data-byte acceptance to out_valid.
REQ-026: Output fields SHALL hold stable while out_valid && !out_ready.
REQ-027: out_valid SHALL clear on out_ready when no new data byte is accepted in that cycle.
REQ-028: Simultaneous out_ready and data-byte acceptance SHALL replace the output register, keeping out_valid = 1.
REQ-029: A channel byte SHALL update the channel register immediately; an already-registered output beat SHALL keep its old channel.
REQ-030: SOP marker followed by EOP marker followed by a data byte SHALL emit a single beat with both sop = 1 and eop = 1.
REQ-031: A repeated SOP or EOP marker before the next data byte SHALL be idempotent.
REQ-032: A consumed 0x7A SHALL cancel pending escape and channel state.
REQ-033: In-band out-of-range channels SHALL be passed unchanged; filtering is downstream.

Reset
REQ-034: While reset = 1, out_valid, out_startofpacket, and out_endofpacket SHALL be 0; out_data and out_channel SHALL be 0x00.
REQ-035: While reset = 1, the channel register and all decode flags SHALL be 0.
REQ-036: While reset = 1, in_ready SHALL be 1, per REQ-014.
REQ-037: Reset asserted mid-packet SHALL discard the held beat and all pending flags with no partial output.
REQ-038: The first beat after reset SHALL carry channel 0 unless a channel marker precedes it.

Verification
REQ-039: Bench SHALL drive bytes 7A 7C 00 11 22 7B 33 with out_ready = 1 -> beats 11 (sop, ch0), 22, 33 (eop), one per cycle with one-cycle latency.
REQ-040: Bench SHALL drive bytes 7A 7D 5A 7B 7D 5D -> beats 7A (sop), 7D (eop).
REQ-041: Bench SHALL drive bytes 7C 7D 5C 7A 7B 44 -> a single beat 44 with channel 0x7C, sop = 1, eop = 1.
REQ-042: Bench SHALL hold out_ready = 0 with beat 11 registered -> in_ready = 0, outputs stable for 5 cycles; on release, next byte 22 SHALL appear in the following cycle.
REQ-043: Bench SHALL drive bytes 7A 7D then assert reset for 1 cycle, then drive 55 -> beat 55 with sop = 0, channel 0, not escaped.
REQ-044: Bench SHALL drive 7C 03 55 with out_ready toggling 1/0 each cycle -> beat 55 on channel 03, no byte dropped or duplicated, and in_ready SHALL match REQ-014 every cycle.
